fpmul_stage3_pipe: RTL and testbench

Parametrised normalise/round stage for the floating-point multiplier pipeline, placed after the significand-product stage and before the final pack/exception stage. It performs 1-bit post-multiply normalisation, configurable rounding and post-round renormalisation for generic exponent/significand widths. Classification flags are carried alongside the data. Two internal register slots with a valid/ready handshake provide stall tolerance without data loss.

---
 rtl/fpmul_stage3_pipe.sv | 250 +++++++++++++++++++++++++
 tb/tb_fpmul_stage3_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_stage3_pipe.sv
// ----------------------------------------------------------------------------
// fpmul_stage3_pipe
// Normalise/round stage of the floating-point multiplier pipeline.
// It sits between the significand-product stage and the pack/exception stage.
//   Slot A : 1-bit post-multiply normalisation of the incoming product.
//   Slot B : rounding and post-round renormalisation. Slot B drives all outputs.
// The two slots form a valid/ready skid pair, so stalls lose no data.
//
// Build option:
//   FPMUL_STAGE3_RNE_EN defined   -> round to nearest, ties to even
//   FPMUL_STAGE3_RNE_EN undefined -> truncation toward zero
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready upstream handshake; in_ready depends only on state and out_ready
//   EXP_in, SIG_in      biased exponent and unnormalised significand
//                       SIG_in layout: [SW-1] ovf, [SW-2] hidden, [2:0] G/R/S
//   *_in flags          sign/INF/NaN/zero/exp-pos/exp-neg, carried unchanged
//   out_valid/out_ready downstream handshake
//   EXP_out, SIG_out    rounded exponent and significand (GRS cleared)
//   EXP_ovf             an exponent increment in this stage wrapped past all-ones
//   *_out flags         sideband flags, delayed with the data
// ----------------------------------------------------------------------------
package fpmul_stage3_pipe_pkg;

   // Sideband classification flags travelling with each beat
   typedef struct packed {
      logic sign;
      logic is_inf;
      logic is_nan;
      logic is_z;
      logic exp_pos;
      logic exp_neg;
   } flags_t;

endpackage

module fpmul_stage3_pipe
   import fpmul_stage3_pipe_pkg::*;
#(
   parameter int unsigned EXP_WIDTH = 8,
   parameter int unsigned SIG_WIDTH = 28
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_WIDTH-1:0] EXP_in,
   input  logic [SIG_WIDTH-1:0] SIG_in,
   input  logic                 SIGN_in,
   input  logic                 isINF_in,
   input  logic                 isNaN_in,
   input  logic                 isZ_in,
   input  logic                 EXP_pos_in,
   input  logic                 EXP_neg_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_WIDTH-1:0] EXP_out,
   output logic [SIG_WIDTH-1:0] SIG_out,
   output logic                 EXP_ovf,
   output logic                 SIGN_out,
   output logic                 isINF_out,
   output logic                 isNaN_out,
   output logic                 isZ_out,
   output logic                 EXP_pos_out,
   output logic                 EXP_neg_out
);

   localparam int unsigned RND_WIDTH = SIG_WIDTH + 1;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                 va_q, va_d;
   logic                 vb_q, vb_d;

   logic [EXP_WIDTH-1:0] exp_a_q, exp_a_d;
   logic [SIG_WIDTH-1:0] sig_a_q, sig_a_d;
   logic                 wrap_a_q, wrap_a_d;
   flags_t               flags_a_q, flags_a_d;

   logic [EXP_WIDTH-1:0] exp_b_q, exp_b_d;
   logic [SIG_WIDTH-1:0] sig_b_q, sig_b_d;
   logic                 ovf_b_q, ovf_b_d;
   flags_t               flags_b_q, flags_b_d;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic adv_a;
   logic adv_b;
   logic load_a;
   logic load_b;

   // B can take new content when it is empty or being consumed; A likewise behind B
   always_comb begin
      adv_b  = !vb_q || out_ready;
      adv_a  = !va_q || adv_b;
      load_a = adv_a && in_valid;
      load_b = va_q && adv_b;
   end

   assign in_ready = adv_a;

   // ------------------------------------------------------------------
   // Normalise (feeds slot A)
   // ------------------------------------------------------------------
   logic [EXP_WIDTH-1:0] exp_n;
   logic [SIG_WIDTH-1:0] sig_n;
   logic                 wrap_n;
   flags_t               flags_in;

   always_comb begin
      flags_in = '{sign:    SIGN_in,
                   is_inf:  isINF_in,
                   is_nan:  isNaN_in,
                   is_z:    isZ_in,
                   exp_pos: EXP_pos_in,
                   exp_neg: EXP_neg_in};
   end

   // Overflow bit set: shift right once, folding the dropped bit into sticky
   always_comb begin
      exp_n  = EXP_in;
      sig_n  = SIG_in;
      wrap_n = 1'b0;
      if (SIG_in[SIG_WIDTH-1]) begin
         sig_n  = {1'b0, SIG_in[SIG_WIDTH-1:2], SIG_in[1] | SIG_in[0]};
         exp_n  = EXP_in + EXP_WIDTH'(1);
         wrap_n = &EXP_in;
      end
   end

   // ------------------------------------------------------------------
   // Round (slot A -> slot B)
   // ------------------------------------------------------------------
   logic                 inc;
   logic                 carry;
   logic [RND_WIDTH-1:0] sig_trunc;
   logic [RND_WIDTH-1:0] sig_sum;
   logic [SIG_WIDTH-1:0] sig_shift;
   logic [EXP_WIDTH-1:0] exp_r;
   logic [SIG_WIDTH-1:0] sig_r;
   logic                 ovf_r;

`ifdef FPMUL_STAGE3_RNE_EN
   // Round up above the halfway point, and on an exact tie only when the kept LSB is odd
   always_comb begin
      inc = sig_a_q[2] & (sig_a_q[1] | sig_a_q[0] | sig_a_q[3]);
   end
`else
   always_comb begin
      inc = 1'b0;
   end
`endif

   // Carry out of the fraction lands on the overflow bit; renormalise by one
   always_comb begin
      sig_trunc = {1'b0, sig_a_q} & ~RND_WIDTH'(7);
      sig_sum   = sig_trunc + (RND_WIDTH'(inc) << 3);
      carry     = sig_sum[SIG_WIDTH-1];
      sig_shift = carry ? sig_sum[SIG_WIDTH:1] : sig_sum[SIG_WIDTH-1:0];
      sig_r     = sig_shift & ~SIG_WIDTH'(7);
      exp_r     = carry ? exp_a_q + EXP_WIDTH'(1) : exp_a_q;
      ovf_r     = wrap_a_q | (carry & (&exp_a_q));
   end

   // ------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------
   // Slot A: refilled whenever it can advance; valid follows in_valid then
   always_comb begin
      va_d      = va_q;
      exp_a_d   = exp_a_q;
      sig_a_d   = sig_a_q;
      wrap_a_d  = wrap_a_q;
      flags_a_d = flags_a_q;
      if (adv_a) begin
         va_d = in_valid;
      end
      if (load_a) begin
         exp_a_d   = exp_n;
         sig_a_d   = sig_n;
         wrap_a_d  = wrap_n;
         flags_a_d = flags_in;
      end
   end

   // Slot B: takes A's rounded content, or empties when A has nothing to give
   always_comb begin
      vb_d      = vb_q;
      exp_b_d   = exp_b_q;
      sig_b_d   = sig_b_q;
      ovf_b_d   = ovf_b_q;
      flags_b_d = flags_b_q;
      if (adv_b) begin
         vb_d = va_q;
      end
      if (load_b) begin
         exp_b_d   = exp_r;
         sig_b_d   = sig_r;
         ovf_b_d   = ovf_r;
         flags_b_d = flags_a_q;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         va_q      <= 1'b0;
         exp_a_q   <= '0;
         sig_a_q   <= '0;
         wrap_a_q  <= 1'b0;
         flags_a_q <= '0;
         vb_q      <= 1'b0;
         exp_b_q   <= '0;
         sig_b_q   <= '0;
         ovf_b_q   <= 1'b0;
         flags_b_q <= '0;
      end else begin
         va_q      <= va_d;
         exp_a_q   <= exp_a_d;
         sig_a_q   <= sig_a_d;
         wrap_a_q  <= wrap_a_d;
         flags_a_q <= flags_a_d;
         vb_q      <= vb_d;
         exp_b_q   <= exp_b_d;
         sig_b_q   <= sig_b_d;
         ovf_b_q   <= ovf_b_d;
         flags_b_q <= flags_b_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs (straight from slot B)
   // ------------------------------------------------------------------
   assign out_valid   = vb_q;
   assign EXP_out     = exp_b_q;
   assign SIG_out     = sig_b_q;
   assign EXP_ovf     = ovf_b_q;
   assign SIGN_out    = flags_b_q.sign;
   assign isINF_out   = flags_b_q.is_inf;
   assign isNaN_out   = flags_b_q.is_nan;
   assign isZ_out     = flags_b_q.is_z;
   assign EXP_pos_out = flags_b_q.exp_pos;
   assign EXP_neg_out = flags_b_q.exp_neg;

endmodule

// File: tb/tb_fpmul_stage3_pipe.sv
// ----------------------------------------------------------------------------
// tb_fpmul_stage3_pipe
// Scoreboard bench for fpmul_stage3_pipe (8-bit exponent, 28-bit significand).
// Expected beats are computed with integer arithmetic when a beat is accepted;
// a negedge monitor compares the head of the queue whenever out_valid is high.
// ----------------------------------------------------------------------------
module tb_fpmul_stage3_pipe;

   localparam int EW = 8;
   localparam int SW = 28;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [EW-1:0] EXP_in;
   logic [SW-1:0] SIG_in;
   logic          SIGN_in, isINF_in, isNaN_in, isZ_in, EXP_pos_in, EXP_neg_in;
   logic          out_valid;
   logic          out_ready;
   logic [EW-1:0] EXP_out;
   logic [SW-1:0] SIG_out;
   logic          EXP_ovf;
   logic          SIGN_out, isINF_out, isNaN_out, isZ_out, EXP_pos_out, EXP_neg_out;

   fpmul_stage3_pipe #(.EXP_WIDTH(EW), .SIG_WIDTH(SW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .EXP_in     (EXP_in),
      .SIG_in     (SIG_in),
      .SIGN_in    (SIGN_in),
      .isINF_in   (isINF_in),
      .isNaN_in   (isNaN_in),
      .isZ_in     (isZ_in),
      .EXP_pos_in (EXP_pos_in),
      .EXP_neg_in (EXP_neg_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .EXP_out    (EXP_out),
      .SIG_out    (SIG_out),
      .EXP_ovf    (EXP_ovf),
      .SIGN_out   (SIGN_out),
      .isINF_out  (isINF_out),
      .isNaN_out  (isNaN_out),
      .isZ_out    (isZ_out),
      .EXP_pos_out(EXP_pos_out),
      .EXP_neg_out(EXP_neg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] sig;
      logic [EW-1:0] exp;
      logic [5:0]    flg;
   } beat_t;

   typedef struct {
      logic [SW-1:0] sig;
      logic [EW-1:0] exp;
      logic          ovf;
      logic [5:0]    flg;
   } res_t;

   res_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input bit ok, input logic [63:0] act,
                        input logic [63:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
   endtask

   // Reference: treat the significand as an integer and apply the rounding rules
   function automatic res_t model(input beat_t b);
      res_t    r;
      longint  s;
      longint  frac;
      longint  base;
      int      e;
      bit      ovf;
      s   = longint'(b.sig);
      e   = int'(b.exp);
      ovf = 1'b0;
      if (s >= (longint'(1) << (SW - 1))) begin
         s = (s >> 1) | (s & 1);
         e = e + 1;
         if (e > 255) begin e = 0; ovf = 1'b1; end
      end
      frac = s % 8;
      base = s - frac;
`ifdef FPMUL_STAGE3_RNE_EN
      if (frac > 4 || (frac == 4 && ((base / 8) % 2) == 1)) base = base + 8;
`endif
      if (base >= (longint'(1) << (SW - 1))) begin
         base = base / 2;
         base = base - (base % 8);
         e = e + 1;
         if (e > 255) begin e = 0; ovf = 1'b1; end
      end
      r.sig = SW'(base);
      r.exp = EW'(e);
      r.ovf = ovf;
      r.flg = b.flg;
      return r;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.sig = SW'($urandom);
      case ($urandom_range(0, 3))
         0:       b.sig[2:0]  = 3'b100;
         1:       b.sig[26:3] = '1;
         default: ;
      endcase
      b.exp = ($urandom_range(0, 3) == 0) ? 8'hFF : EW'($urandom);
      b.flg = 6'($urandom);
      return b;
   endfunction

   function automatic beat_t mk(input logic [SW-1:0] sig, input logic [EW-1:0] exp,
                                input logic [5:0] flg);
      beat_t b;
      b.sig = sig;
      b.exp = exp;
      b.flg = flg;
      return b;
   endfunction

   // One clock of stimulus; inputs change #1 after the rising edge
   task automatic drive_cycle(input bit v, input beat_t b, input bit ordy, output bit acc);
      @(posedge clk);
      #1;
      in_valid  = v;
      SIG_in    = b.sig;
      EXP_in    = b.exp;
      {SIGN_in, isINF_in, isNaN_in, isZ_in, EXP_pos_in, EXP_neg_in} = b.flg;
      out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (acc) sb.push_back(model(b));
   endtask

   // Monitor: every presented beat must match the queue head, stalled or not
   res_t          mon_e;
   logic [63:0]   mon_got;
   logic [63:0]   mon_req;
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         mon_got = {21'd0, EXP_ovf,
                    SIGN_out, isINF_out, isNaN_out, isZ_out, EXP_pos_out, EXP_neg_out,
                    EXP_out, SIG_out};
         if (sb.size() == 0) begin
            check("unexpected_beat", 1'b0, mon_got, 64'd0);
         end else begin
            mon_e   = sb[0];
            mon_req = {21'd0, mon_e.ovf, mon_e.flg, mon_e.exp, mon_e.sig};
            check("out_beat", mon_got === mon_req, mon_got, mon_req);
            if (out_ready) sb.delete(0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   beat_t dir[8];
   beat_t cur;
   beat_t idle_b;
   bit    acc;
   bit    pend;

   initial begin
      idle_b = mk(28'h0, 8'h0, 6'h0);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      SIG_in = '0;
      EXP_in = '0;
      {SIGN_in, isINF_in, isNaN_in, isZ_in, EXP_pos_in, EXP_neg_in} = 6'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
      check("rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
      check("rst_data", {EXP_ovf, EXP_out, SIG_out} == '0, 64'({EXP_ovf, EXP_out, SIG_out}), 64'd0);
      check("rst_flags", {SIGN_out, isINF_out, isNaN_out, isZ_out, EXP_pos_out, EXP_neg_out} == 6'h0,
            64'({SIGN_out, isINF_out, isNaN_out, isZ_out, EXP_pos_out, EXP_neg_out}), 64'd0);
      #2 rst_n = 1'b1;

      // Directed vectors: exact, normalise, ties, round carry, both wraps
      dir[0] = mk(28'h4000000, 8'h80, 6'h01);
      dir[1] = mk(28'h8000000, 8'h7F, 6'h02);
      dir[2] = mk(28'h4000004, 8'h80, 6'h04);
      dir[3] = mk(28'h400000C, 8'h80, 6'h08);
      dir[4] = mk(28'h4000006, 8'h80, 6'h10);
      dir[5] = mk(28'h7FFFFFC, 8'h80, 6'h20);
      dir[6] = mk(28'h7FFFFFC, 8'hFF, 6'h3F);
      dir[7] = mk(28'hFFFFFFF, 8'hFF, 6'h15);
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, dir[i], 1'b1, acc);
         check("dir_accept", acc, 64'(acc), 64'd1);
      end
      repeat (3) drive_cycle(1'b0, idle_b, 1'b1, acc);

      // Backpressure: two accepts fill the stage, third waits for release
      drive_cycle(1'b1, mk(28'h4000010, 8'h10, 6'd1), 1'b0, acc);
      check("bp_acc1", acc, 64'(acc), 64'd1);
      drive_cycle(1'b1, mk(28'h4000020, 8'h20, 6'd2), 1'b0, acc);
      check("bp_acc2", acc, 64'(acc), 64'd1);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, mk(28'h4000030, 8'h30, 6'd3), 1'b0, acc);
         check("bp_full_in_ready", acc == 1'b0, 64'(in_ready), 64'd0);
      end
      drive_cycle(1'b1, mk(28'h4000030, 8'h30, 6'd3), 1'b1, acc);
      check("bp_release_accept", acc, 64'(acc), 64'd1);
      repeat (4) drive_cycle(1'b0, idle_b, 1'b1, acc);
      check("bp_drained", sb.size() == 0, 64'(sb.size()), 64'd0);

      // Randomised traffic with random stalls
      pend = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (!pend) cur = rand_beat();
         pend = ($urandom_range(0, 3) != 0);
         drive_cycle(pend, cur, ($urandom_range(0, 3) != 0), acc);
         if (acc) pend = 1'b0;
      end
      for (int i = 0; i < 20 && sb.size() != 0; i++) drive_cycle(1'b0, idle_b, 1'b1, acc);
      check("rand_drained", sb.size() == 0, 64'(sb.size()), 64'd0);

      // Reset mid-stream with two beats in flight
      drive_cycle(1'b1, mk(28'h4000008, 8'h44, 6'h2A), 1'b0, acc);
      drive_cycle(1'b1, mk(28'h5000008, 8'h45, 6'h15), 1'b0, acc);
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
      check("mid_rst_data", {EXP_ovf, EXP_out, SIG_out} == '0, 64'({EXP_ovf, EXP_out, SIG_out}), 64'd0);
      check("mid_rst_flags", {SIGN_out, isINF_out, isNaN_out, isZ_out, EXP_pos_out, EXP_neg_out} == 6'h0,
            64'({SIGN_out, isINF_out, isNaN_out, isZ_out, EXP_pos_out, EXP_neg_out}), 64'd0);
      sb.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;

      // First beat after reset: out_valid exactly two cycles after accept
      drive_cycle(1'b1, mk(28'h400000C, 8'h7E, 6'h33), 1'b1, acc);
      check("post_rst_accept", acc, 64'(acc), 64'd1);
      drive_cycle(1'b0, idle_b, 1'b1, acc);
      @(negedge clk);
      check("lat_cycle1", out_valid == 1'b0, 64'(out_valid), 64'd0);
      drive_cycle(1'b0, idle_b, 1'b1, acc);
      @(negedge clk);
      check("lat_cycle2", out_valid == 1'b1, 64'(out_valid), 64'd1);
      repeat (3) drive_cycle(1'b0, idle_b, 1'b1, acc);
      check("final_drained", sb.size() == 0, 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
